// File: rtl/game_pkg.sv
// game_pkg: state encodings and timing defaults shared by the game-flow, score and display blocks.
package game_pkg;
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAYING   = 2'd2,
        ST_GAME_OVER = 2'd3
    } state_t;
    localparam int BEAT_DIV_DEFAULT = 12500000;
endpackage

// File: rtl/beat_divider.sv
// beat_divider: free-running beat counter gated by run, with a registered one-cycle tick on wrap.
module beat_divider
    import game_pkg::*;
#(
    parameter int BEAT_DIV = BEAT_DIV_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic run,
    output logic tick
);
    localparam int CW = $clog2(BEAT_DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    logic tick_q, wrap;
    assign wrap  = cnt_q == CW'(BEAT_DIV - 1);
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
    assign tick  = tick_q;
    // Dropping run parks the counter at 0 so the next beat is a full BEAT_DIV cycles long.
    always_ff @(posedge CLOCK_50) begin
        if (reset || !run) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap;
        end
    end
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: IDLE/COUNTDOWN/PLAYING/GAME_OVER flow, per-beat hit/miss judging and score commands.
module game_sequencer
    import game_pkg::*;
#(
    parameter int BEAT_DIV        = BEAT_DIV_DEFAULT,
    parameter int COUNTDOWN_BEATS = 3,
    parameter int MAX_MISSES      = 3
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       start,
    input  logic       key_hit,
    input  logic       key_wrong,
    output logic [1:0] state,
    output logic       beat_tick,
    output logic       score_inc,
    output logic       score_clear,
    output logic [1:0] countdown,
    output logic [1:0] misses
);
    state_t     state_q;
    logic       start_q, hit_q, wrong_q, inc_q, clear_q;
    logic       start_rise, hit_d, wrong_d, run;
    logic [1:0] cd_q, miss_q, miss_d;

    assign start_rise  = start & ~start_q;
    assign hit_d       = hit_q | key_hit;
    assign wrong_d     = wrong_q | key_wrong;
    assign miss_d      = miss_q + 2'd1;
    assign run         = state_q == ST_COUNTDOWN || state_q == ST_PLAYING;
    assign state       = state_q;
    assign score_inc   = inc_q;
    assign score_clear = clear_q;
    assign countdown   = cd_q;
    assign misses      = miss_q;

    beat_divider #(.BEAT_DIV(BEAT_DIV)) u_beat (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .run     (run),
        .tick    (beat_tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            hit_q   <= 1'b0;
            wrong_q <= 1'b0;
            inc_q   <= 1'b0;
            clear_q <= 1'b0;
            cd_q    <= 2'd0;
            miss_q  <= 2'd0;
        end else begin
            start_q <= start;
            inc_q   <= 1'b0;
            clear_q <= 1'b0;
            hit_q   <= 1'b0;
            wrong_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_GAME_OVER: if (start_rise) begin
                    state_q <= ST_COUNTDOWN;
                    cd_q    <= 2'(COUNTDOWN_BEATS);
                    miss_q  <= 2'd0;
                    clear_q <= 1'b1;
                end
                ST_COUNTDOWN: if (beat_tick) begin
                    cd_q <= cd_q - 2'd1;
                    if (cd_q == 2'd1) state_q <= ST_PLAYING;
                end
                // The tick cycle judges latch OR live key, so a press on the tick still counts.
                ST_PLAYING: if (beat_tick) begin
                    if (hit_d && !wrong_d) inc_q <= 1'b1;
                    else begin
                        miss_q <= miss_d;
                        if (miss_d == 2'(MAX_MISSES)) state_q <= ST_GAME_OVER;
                    end
                end else begin
                    hit_q   <= hit_d;
                    wrong_q <= wrong_d;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed game flow with a pulse scoreboard for score_inc/score_clear.
module tb_game_sequencer;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1, start = 1'b0, key_hit = 1'b0, key_wrong = 1'b0;
    logic [1:0] state, countdown, misses;
    logic       beat_tick, score_inc, score_clear;
    int         cyc = 0, checks = 0, errors = 0;

    typedef struct { bit inc; int cyc; } ev_t;
    ev_t sb[$];
    ev_t ev;

    game_sequencer #(.BEAT_DIV(4), .COUNTDOWN_BEATS(3), .MAX_MISSES(3)) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .start      (start),
        .key_hit    (key_hit),
        .key_wrong  (key_wrong),
        .state      (state),
        .beat_tick  (beat_tick),
        .score_inc  (score_inc),
        .score_clear(score_clear),
        .countdown  (countdown),
        .misses     (misses)
    );

    always #5 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_tick(output int t);
        bit found = 1'b0;
        t = -1;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (beat_tick) begin
                found = 1'b1;
                t = cyc;
            end
        end
        if (!found) chk("tick_timeout", 0, 1);
    endtask

    always @(negedge CLOCK_50) begin
        if (score_inc || score_clear) begin
            chk("pulse_excl", int'(score_inc & score_clear), 0);
            if (sb.size() == 0) chk("extra_pulse", 1, 0);
            else begin
                ev = sb.pop_front();
                chk("pulse_kind", int'(score_inc), int'(ev.inc));
                chk("pulse_cyc", cyc, ev.cyc);
            end
        end
    end

    initial begin
        int t, e0, p, n;
        step();
        step();
        reset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_tick", beat_tick, 0);
        chk("rst_inc", score_inc, 0);
        chk("rst_clear", score_clear, 0);
        chk("rst_cd", countdown, 0);
        chk("rst_miss", misses, 0);
        step();
        // start from IDLE: countdown 3,2,1 then PLAYING
        start = 1'b1;
        sb.push_back('{1'b0, cyc + 1});
        step();
        start = 1'b0;
        e0 = cyc;
        chk("cd_state", state, 1);
        chk("cd_load", countdown, 3);
        for (int k = 1; k <= 3; k++) begin
            wait_tick(t);
            chk("cd_tick_time", t, e0 + 4 * k);
            step();
            chk("cd_value", countdown, 3 - k);
        end
        chk("play_state", state, 2);
        p = cyc;
        // key_hit held for three beats -> one score_inc per beat
        key_hit = 1'b1;
        for (int j = 0; j < 3; j++) begin
            wait_tick(t);
            chk("hold_tick_time", t, p + 3 + 4 * j);
            sb.push_back('{1'b1, t + 1});
        end
        key_hit = 1'b0;
        step();
        chk("hold_miss", misses, 0);
        // press only on the tick cycle -> HIT
        wait_tick(t);
        key_hit = 1'b1;
        sb.push_back('{1'b1, t + 1});
        step();
        key_hit = 1'b0;
        chk("tickpress_miss", misses, 0);
        // both keys within one beat -> MISS
        key_hit = 1'b1;
        step();
        key_hit = 1'b0;
        key_wrong = 1'b1;
        step();
        key_wrong = 1'b0;
        wait_tick(t);
        step();
        chk("both_miss", misses, 1);
        chk("both_state", state, 2);
        // silent beats until the miss limit
        wait_tick(t);
        step();
        chk("miss2", misses, 2);
        chk("miss2_state", state, 2);
        wait_tick(t);
        step();
        chk("miss3", misses, 3);
        chk("gameover_state", state, 3);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (beat_tick) n++;
        end
        chk("gameover_ticks", n, 0);
        chk("gameover_hold", state, 3);
        chk("gameover_cd", countdown, 0);
        chk("gameover_miss", misses, 3);
        // restart from GAME_OVER
        start = 1'b1;
        sb.push_back('{1'b0, cyc + 1});
        step();
        start = 1'b0;
        chk("restart_state", state, 1);
        chk("restart_miss", misses, 0);
        chk("restart_cd", countdown, 3);
        for (int k = 0; k < 3; k++) begin
            wait_tick(t);
            step();
        end
        chk("replay_state", state, 2);
        // start during PLAYING is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("play_start_ignored", state, 2);
        // reset mid-beat with the hit latch set: no score_inc afterwards
        key_hit = 1'b1;
        step();
        key_hit = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_state", state, 0);
        chk("midrst_tick", beat_tick, 0);
        chk("midrst_inc", score_inc, 0);
        chk("midrst_clear", score_clear, 0);
        chk("midrst_cd", countdown, 0);
        chk("midrst_miss", misses, 0);
        for (int i = 0; i < 6; i++) step();
        chk("midrst_idle", state, 0);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
